// File: rtl/nonce_pkg.sv
// Shared types and sizes for the nonce search controller and its helpers.
package nonce_pkg;

    localparam int unsigned HASH_W      = 24;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned ENTRY_BYTES = 12;
    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned ENTRY_W     = ENTRY_BYTES * BYTE_W;

    typedef enum logic [1:0] {
        StIdle,
        StClr,
        StWait,
        StCheck
    } state_e;

endpackage

// File: rtl/nonce_target_cmp.sv
// Difficulty test on a returned hash: both low bytes must be strictly below target.
// The top byte of the hash never takes part, so only the two low bytes come in.
module nonce_target_cmp
    import nonce_pkg::*;
(
    input  logic [BYTE_W-1:0] i_byte0,
    input  logic [BYTE_W-1:0] i_byte1,
    input  logic [BYTE_W-1:0] i_target,
    output logic              o_hit
);

    // Unsigned compare of each byte against the threshold
    always_comb begin
        o_hit = (i_byte0 < i_target) && (i_byte1 < i_target);
    end

endmodule

// File: rtl/nonce_search_ctrl.sv
// Search controller: restarts the hash engine per nonce, waits for done, tests the
// hash against target and steps the nonce until a hit, the limit, or a timeout.
module nonce_search_ctrl
    import nonce_pkg::*;
#(
    parameter int unsigned        NONCE_W     = 32,
    parameter logic [NONCE_W-1:0] START_NONCE = '0,
    parameter int unsigned        TIMEOUT     = 64,
    parameter int unsigned        GUARD       = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [ENTRY_W-1:0] i_entry_12,
    input  logic [BYTE_W-1:0]  i_target,
    input  logic [NONCE_W-1:0] i_nonce_limit,
    output logic [ENTRY_W-1:0] o_entry_out,
    output logic [NONCE_W-1:0] o_nonce,
    output logic               o_selector,
    output logic               o_hash_clr,
    input  logic               i_hash_done,
    input  logic [HASH_W-1:0]  i_hash_in,
    output logic               o_busy,
    output logic               o_found,
    output logic               o_exhausted,
    output logic               o_timeout_err,
    output logic [NONCE_W-1:0] o_win_nonce,
    output logic [HASH_W-1:0]  o_win_hash
);

    localparam int unsigned      CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

    state_e             r_state;
    state_e             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [HASH_W-1:0]  r_hash;
    logic [BYTE_W-1:0]  r_target;
    logic [NONCE_W-1:0] r_limit;
    logic [ENTRY_W-1:0] r_entry;
    logic [NONCE_W-1:0] r_nonce;
    logic               r_selector;
    logic               r_hash_clr;
    logic               r_busy;
    logic               r_found;
    logic               r_exhausted;
    logic               r_timeout_err;
    logic [NONCE_W-1:0] r_win_nonce;
    logic [HASH_W-1:0]  r_win_hash;

    logic w_hit;
    logic w_accept;
    logic w_capture;
    logic w_timeout;
    logic w_hit_set;
    logic w_exh_set;
    logic w_step;

    nonce_target_cmp u_cmp (
        .i_byte0  (r_hash[BYTE_W-1:0]),
        .i_byte1  (r_hash[2*BYTE_W-1:BYTE_W]),
        .i_target (r_target),
        .o_hit    (w_hit)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle action strobes
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_hit_set    = 1'b0;
        w_exh_set    = 1'b0;
        w_step       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = StClr;
                end
            end
            StClr: begin
                w_state_next = StWait;
            end
            StWait: begin
                // A qualifying done beats the timeout on the same cycle
                if (i_hash_done && (r_cnt >= CNT_GUARD)) begin
                    w_capture    = 1'b1;
                    w_state_next = StCheck;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = StIdle;
                end
            end
            StCheck: begin
                if (w_hit) begin
                    w_hit_set    = 1'b1;
                    w_state_next = StIdle;
                end else if (r_nonce == r_limit) begin
                    w_exh_set    = 1'b1;
                    w_state_next = StIdle;
                end else begin
                    w_step       = 1'b1;
                    w_state_next = StClr;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Datapath, result registers and outputs; strobes are registered off the next state
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt         <= '0;
            r_hash        <= '0;
            r_target      <= '0;
            r_limit       <= '0;
            r_entry       <= '0;
            r_nonce       <= START_NONCE;
            r_selector    <= 1'b0;
            r_hash_clr    <= 1'b0;
            r_busy        <= 1'b0;
            r_found       <= 1'b0;
            r_exhausted   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_win_nonce   <= '0;
            r_win_hash    <= '0;
        end else begin
            r_hash_clr <= (w_state_next == StClr);
            r_selector <= (w_state_next != StIdle);
            r_busy     <= (w_state_next != StIdle);
            if (r_state == StClr) begin
                r_cnt <= '0;
            end else if (r_state == StWait) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_entry       <= i_entry_12;
                r_target      <= i_target;
                r_limit       <= i_nonce_limit;
                r_nonce       <= START_NONCE;
                r_found       <= 1'b0;
                r_exhausted   <= 1'b0;
                r_timeout_err <= 1'b0;
            end
            if (w_capture) begin
                r_hash <= i_hash_in;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
            if (w_hit_set) begin
                r_found     <= 1'b1;
                r_win_nonce <= r_nonce;
                r_win_hash  <= r_hash;
            end
            if (w_exh_set) begin
                r_exhausted <= 1'b1;
            end
            if (w_step) begin
                r_nonce <= r_nonce + 1'b1;
            end
        end
    end

    assign o_entry_out   = r_entry;
    assign o_nonce       = r_nonce;
    assign o_selector    = r_selector;
    assign o_hash_clr    = r_hash_clr;
    assign o_busy        = r_busy;
    assign o_found       = r_found;
    assign o_exhausted   = r_exhausted;
    assign o_timeout_err = r_timeout_err;
    assign o_win_nonce   = r_win_nonce;
    assign o_win_hash    = r_win_hash;

endmodule
